// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage behind the execute ALU.
// Takes the ALU result as the effective byte address. Runs one data-memory
// transaction per accepted op over a req/ack bus. Emits one writeback pulse
// per op.
//
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   ex_valid/ready  : op handshake from EX (ex_ready = idle && !flush)
//   mem_read/write  : op kind
//   funct3          : size/sign (B, H, W, BU, HU)
//   alu_result      : effective byte address
//   store_data, rd_in : rs2 value and load destination
//   flush           : blocks acceptance and silences a pending writeback
//   dmem_*          : registered bus request (req held until ack or timeout)
//   wb_*            : one-cycle writeback pulse with extended data and error
//   state_dbg       : current FSM state (0 idle, 1 busy, 2 resp)
//
// Handshake semantics: an op is taken on a rising edge where
// ex_valid && ex_ready. A bus transaction completes on the first rising edge
// in BUSY where dmem_ack is high. dmem_rdata is sampled on that same edge.
module lsu_mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic [1:0]  state_dbg
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Counter value on the last BUSY cycle before timeout.
  localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [9:0]  wait_cnt;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic        op_load;
  logic [4:0]  op_rd;
  logic        flushed;

  logic        accept;
  logic        op_illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        squash;

  assign ex_ready  = (state == IDLE) && !flush;
  assign accept    = ex_valid && ex_ready;
  assign state_dbg = state;
  // A flush seen on the completing cycle also counts as "seen since accept".
  assign squash    = flushed || flush;

  always_comb begin
    op_illegal = (mem_read == mem_write);
    case (funct3)
      F3_B:    ;
      F3_BU:   if (mem_write) op_illegal = 1'b1;
      F3_H:    if (alu_result[0]) op_illegal = 1'b1;
      F3_HU:   if (mem_write || alu_result[0]) op_illegal = 1'b1;
      F3_W:    if (alu_result[1:0] != 2'b00) op_illegal = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
      default: ;
    endcase
  end

  // Lane extraction uses the latched offset. The bus address is word aligned.
  always_comb begin
    ld_byte = dmem_rdata[{op_off, 3'b000} +: 8];
    ld_half = dmem_rdata[{op_off[1], 4'b0000} +: 16];
    case (op_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      op_f3      <= '0;
      op_off     <= '0;
      op_load    <= 1'b0;
      op_rd      <= '0;
      flushed    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_f3    <= funct3;
            op_off   <= alu_result[1:0];
            op_load  <= mem_read;
            op_rd    <= rd_in;
            flushed  <= 1'b0;
            wait_cnt <= '0;
            if (op_illegal) begin
              // No bus activity; report the error on the next cycle.
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_data  <= '0;
              wb_rd    <= rd_in;
            end else begin
              state      <= BUSY;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_be    <= mem_write ? st_be : 4'b0000;
              dmem_wdata <= mem_write ? st_wdata : 32'd0;
            end
          end
        end
        BUSY: begin
          if (flush) flushed <= 1'b1;
          if (dmem_ack) begin
            state    <= RESP;
            dmem_req <= 1'b0;
            wb_valid <= !squash;
            wb_we    <= !squash && op_load && (op_rd != 5'd0);
            wb_err   <= 1'b0;
            wb_rd    <= op_rd;
            wb_data  <= op_load ? ld_data : 32'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= RESP;
            dmem_req <= 1'b0;
            wb_valid <= !squash;
            wb_err   <= 1'b1;
            wb_rd    <= op_rd;
            wb_data  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
